// File: rtl/out_fifo.sv
// out_fifo: first-word-fall-through output FIFO between a CPU output strobe
// and an external ready/valid sink.
//
// Optional feature: define OUT_FIFO_STATS_EN to add the words_sent counter
// port (32-bit count of pops since reset, unaffected by clear).
//
// Ports
//   clk         system clock, all state updates on rising edge
//   reset       asynchronous active-high reset (pointers, count, flags)
//   out_signal  push request strobe, one push per high cycle
//   out_data    64-bit word pushed with out_signal
//   clear       synchronous flush, wins over push and pop
//   dev_valid   head word available (= !empty)
//   dev_data    head word, read combinationally from storage
//   dev_ready   sink accepts head word when high with dev_valid
//   full        occupancy == DEPTH
//   empty       occupancy == 0
//   count       occupancy 0..DEPTH
//   overflow    sticky: a push was dropped while full
//   words_sent  (OUT_FIFO_STATS_EN only) pops since reset, wraps at 2^32
module out_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          out_signal,
  input  logic [63:0]   out_data,
  input  logic          clear,
  output logic          dev_valid,
  output logic [63:0]   dev_data,
  input  logic          dev_ready,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
`ifdef OUT_FIFO_STATS_EN
  ,
  output logic [31:0]   words_sent
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = 64;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              overflow_q;
  logic              pop;
  logic              push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign dev_valid = !empty;
  assign dev_data  = mem[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  // when the sink is draining it.
  assign pop  = dev_valid && dev_ready;
  assign push = out_signal && (!full || pop);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= out_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (out_signal && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef OUT_FIFO_STATS_EN
  // Clear suppresses the pop, so it never advances this counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_sent <= '0;
    end else if (pop && !clear) begin
      words_sent <= words_sent + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_out_fifo.sv
module tb_out_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          out_signal = 1'b0;
  logic [63:0]   out_data = '0;
  logic          clear = 1'b0;
  logic          dev_valid;
  logic [63:0]   dev_data;
  logic          dev_ready = 1'b0;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef OUT_FIFO_STATS_EN
  logic [31:0]   words_sent;
`endif

  int checks = 0;
  int errors = 0;

  out_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .out_signal (out_signal),
    .out_data   (out_data),
    .clear      (clear),
    .dev_valid  (dev_valid),
    .dev_data   (dev_data),
    .dev_ready  (dev_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
`ifdef OUT_FIFO_STATS_EN
    ,
    .words_sent (words_sent)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        os;
    logic [63:0] od;
    logic        rdy;
    logic        clr;
    int          e_cnt;
    logic        e_vld;
    logic [63:0] e_dat;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive inputs for one edge, then land 2 time units after that edge.
  task automatic cyc(input logic os, input logic [63:0] od, input logic rdy, input logic clr);
    out_signal = os;
    out_data   = od;
    dev_ready  = rdy;
    clear      = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", dev_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    // ---------------- table vectors ----------------
    //          os   od       rdy  clr  cnt vld dat      full ovf
    vt[0]  = '{1'b1, 64'h11, 1'b0, 1'b0, 1, 1'b1, 64'h11, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 64'h22, 1'b0, 1'b0, 2, 1'b1, 64'h11, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 64'h33, 1'b0, 1'b0, 3, 1'b1, 64'h11, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 64'h00, 1'b0, 1'b0, 3, 1'b1, 64'h11, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 64'h00, 1'b1, 1'b0, 2, 1'b1, 64'h22, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 64'h00, 1'b1, 1'b0, 1, 1'b1, 64'h33, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 64'h00, 1'b1, 1'b0, 0, 1'b0, 64'h00, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 64'h00, 1'b1, 1'b0, 0, 1'b0, 64'h00, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 64'h44, 1'b1, 1'b0, 1, 1'b1, 64'h44, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 64'h55, 1'b1, 1'b0, 1, 1'b1, 64'h55, 1'b0, 1'b0};
    vt[10] = '{1'b1, 64'h66, 1'b0, 1'b0, 2, 1'b1, 64'h55, 1'b0, 1'b0};
    vt[11] = '{1'b1, 64'h77, 1'b1, 1'b1, 0, 1'b0, 64'h00, 1'b0, 1'b0};
    vt[12] = '{1'b1, 64'h88, 1'b0, 1'b0, 1, 1'b1, 64'h88, 1'b0, 1'b0};
    vt[13] = '{1'b0, 64'h00, 1'b1, 1'b0, 0, 1'b0, 64'h00, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].os, vt[i].od, vt[i].rdy, vt[i].clr);
      chk($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d_valid", i), dev_valid, vt[i].e_vld);
      chk($sformatf("vec%0d_empty", i), empty, !vt[i].e_vld);
      chk($sformatf("vec%0d_full", i), full, vt[i].e_full);
      chk($sformatf("vec%0d_ovf", i), overflow, vt[i].e_ovf);
      if (vt[i].e_vld) chk($sformatf("vec%0d_data", i), dev_data, vt[i].e_dat);
    end

    // ---------------- overflow on 9th push, drain order ----------------
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 64'h101 + 64'(i), 1'b0, 1'b0);
      chk($sformatf("ovf_fill%0d_count", i), count, (i < 8) ? i + 1 : 8);
    end
    chk("ovf_full", full, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head", dev_data, 64'h101);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf_drain%0d", k), dev_data, 64'h101 + 64'(k));
      cyc(1'b0, 64'h0, 1'b1, 1'b0);
    end
    chk("ovf_drain_empty", empty, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 1'b0);

    // ---------------- push and pop while full ----------------
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'h201 + 64'(i), 1'b0, 1'b0);
    chk("fullpp_pre_full", full, 1'b1);
    cyc(1'b1, 64'h2AA, 1'b1, 1'b0);
    chk("fullpp_count", count, 8);
    chk("fullpp_ovf", overflow, 1'b0);
    chk("fullpp_full", full, 1'b1);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("fullpp_head%0d", k), dev_data, 64'h202 + 64'(k));
      cyc(1'b0, 64'h0, 1'b1, 1'b0);
    end
    chk("fullpp_new_head", dev_data, 64'h2AA);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    chk("fullpp_empty", empty, 1'b1);

    // ---------------- wrap with continuous pop (fresh reset) ----------------
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) chk($sformatf("wrap_head%0d", i), dev_data, 64'h300 + 64'(i - 1));
      cyc(1'b1, 64'h300 + 64'(i), 1'b1, 1'b0);
      chk($sformatf("wrap_count%0d", i), count, 1);
    end
    chk("wrap_last", dev_data, 64'h313);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    chk("wrap_empty", empty, 1'b1);
`ifdef OUT_FIFO_STATS_EN
    chk("wrap_words_sent", words_sent, 20);
`endif

    // ---------------- clear with push at count 5, overflow set ----------------
    for (int i = 0; i < 9; i++) cyc(1'b1, 64'h401 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 64'h0, 1'b1, 1'b0);
    chk("clr_pre_count", count, 5);
    chk("clr_pre_ovf", overflow, 1'b1);
    cyc(1'b1, 64'h4FF, 1'b0, 1'b1);
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1'b1);
    chk("clr_ovf", overflow, 1'b0);
    idle();
    chk("clr_discard", dev_valid, 1'b0);

    // ---------------- async reset mid-burst ----------------
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'h501 + 64'(i), 1'b0, 1'b0);
    chk("arst_pre_count", count, 3);
    out_signal = 1'b1;
    out_data   = 64'h5EE;
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", dev_valid, 1'b0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1'b1);
    @(posedge clk);
    #2;
    chk("arst_hold_count", count, 0);
    reset = 1'b0;
    cyc(1'b1, 64'h5AA, 1'b0, 1'b0);
    chk("arst_first_head", dev_data, 64'h5AA);
    chk("arst_first_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_fifo.md
OUT_FIFO -- requirements
Module: out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 64-bit entries; power of two, minimum 2.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, width of count.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port out_signal  input  1  CPU output strobe; each cycle high is one push request.
REQ-006 SHALL have port out_data  input  64  CPU output word, sampled with out_signal.
REQ-007 SHALL have port clear  input  1  synchronous flush request.
REQ-008 SHALL have port dev_valid  output  1  head word available to external sink.
REQ-009 SHALL have port dev_data  output  64  head word.
REQ-010 SHALL have port dev_ready  input  1  sink accepts head word when high with dev_valid.
REQ-011 SHALL have port full  output  1  occupancy equals DEPTH.
REQ-012 SHALL have port empty  output  1  occupancy equals 0.
REQ-013 SHALL have port count  output  CW  current occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky flag: a push was dropped.

Function
REQ-015 SHALL be first-word-fall-through: dev_valid = !empty; dev_data = entry at read pointer, combinational from storage.
REQ-016 SHALL perform a push at a rising edge when out_signal=1 and (full=0, or a pop occurs in the same cycle).
REQ-017 SHALL perform a pop at a rising edge when dev_valid=1 and dev_ready=1.
REQ-018 SHALL make a pushed word visible on dev_valid/dev_data in the cycle after the pushing edge; there is no same-cycle bypass when empty.
REQ-019 SHALL leave count unchanged on simultaneous push and pop, and SHALL increment or decrement it by 1 on a push-only or pop-only edge.
REQ-020 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-021 SHALL drop out_data and set overflow when out_signal=1, full=1, and no pop occurs; contents SHALL be unchanged.
REQ-022 SHALL hold overflow at 1 until reset or clear.
REQ-023 SHALL ignore dev_ready while empty; count SHALL never underflow.
REQ-024 SHALL, when clear=1 at an edge, empty the FIFO, zero count, and clear overflow; clear SHALL take priority over a push and a pop in the same cycle.
REQ-025 SHALL hold dev_data stable while dev_valid=1 and dev_ready=0.

Reset
REQ-026 SHALL, on reset assertion, immediately and asynchronously force dev_valid=0, full=0, empty=1, count=0, overflow=0, pointers=0.
REQ-027 SHALL discard in-flight contents on reset mid-operation; storage contents need not be cleared.
REQ-028 SHALL ignore out_signal, dev_ready and clear while reset=1; operation resumes on the first rising edge after deassertion.

Configuration
REQ-029 SHALL use macro OUT_FIFO_STATS_EN.
REQ-030 SHALL, with OUT_FIFO_STATS_EN defined, add output words_sent  output  32  count of pops since reset, wrapping at 2^32, unaffected by clear, reset to 0.
REQ-031 SHALL, without OUT_FIFO_STATS_EN, omit the words_sent port and counter; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover this scenario: push 0x11, 0x22, 0x33 on consecutive cycles with dev_ready=0 -> count=3, dev_data=0x11; then dev_ready=1 -> 0x11, 0x22, 0x33 on consecutive cycles, then empty=1.
REQ-033 SHALL cover this scenario: with DEPTH=8, push 9 words with dev_ready=0 -> full=1, count=8, overflow=1, 9th word absent; drain order = words 1..8.
REQ-034 SHALL cover this scenario: full with dev_ready=1 and out_signal=1 in the same cycle -> count stays 8, no overflow, new word appears after 7 pops.
REQ-035 SHALL cover this scenario: push 20 words while popping continuously (DEPTH=8) -> pointer wrap with output sequence identical to input; words_sent=20 when OUT_FIFO_STATS_EN is defined.
REQ-036 SHALL cover this scenario: count=5 with overflow=1, assert clear together with out_signal -> next cycle count=0, empty=1, overflow=0, pushed word discarded.
REQ-037 SHALL cover this scenario: assert reset mid-burst between clock edges -> dev_valid=0, count=0 before the next edge; the first push after release appears as the head.
